// File: rtl/sram_mem_ctrl_if.sv
// Bundle between the MEM stage and the SRAM sequencer: pipeline request side plus
// the external 16-bit asynchronous SRAM pins.
interface sram_mem_ctrl_if #(
  parameter int ADDR_W = 18
);
  logic              rd_en;
  logic              wr_en;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic              freeze;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_wdata;
  logic              sram_dq_oe;
  logic              sram_we_n;
  logic              sram_oe_n;
  logic [15:0]       sram_rdata;

  modport slave (
    input  rd_en, wr_en, addr, wdata, sram_rdata,
    output rdata, ready, freeze, sram_addr, sram_wdata, sram_dq_oe, sram_we_n, sram_oe_n
  );

  modport master (
    output rd_en, wr_en, addr, wdata, sram_rdata,
    input  rdata, ready, freeze, sram_addr, sram_wdata, sram_dq_oe, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/sram_mem_ctrl.sv
// Splits each 32-bit MEM-stage access into two 16-bit SRAM phases (low half, then high half)
// and freezes the pipeline until the word is complete.
//
// state | meaning
// IDLE  | waiting for rd_en/wr_en; request latched on exit
// LOW   | SRAM phase for half-word 0
// HIGH  | SRAM phase for half-word 1
// DONE  | one-cycle ready pulse, strobes inactive
module sram_mem_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  sram_mem_ctrl_if.slave bus
);
  localparam int                CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(WAIT_CYCLES);
  localparam int                WE_CYCLES = (WAIT_CYCLES > 0) ? WAIT_CYCLES : 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-2:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              op_wr;
  logic              req;
  logic              in_phase;
  logic              phase_end;

  logic              ready_c;
  logic [ADDR_W-1:0] sram_addr_c;
  logic [15:0]       sram_wdata_c;
  logic              dq_oe_c;
  logic              we_n_c;
  logic              oe_n_c;

  assign req       = bus.rd_en | bus.wr_en;
  assign in_phase  = (state == LOW) || (state == HIGH);
  assign phase_end = in_phase && (count == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_wr   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        addr_q  <= bus.addr[ADDR_W:2];
        wdata_q <= bus.wdata;
        op_wr   <= bus.wr_en;
      end
      if (in_phase && !phase_end) count <= count + CNT_W'(1);
      else                        count <= '0;
      // Capture on the last cycle of a read phase, when SRAM access time has elapsed
      if (phase_end && !op_wr) begin
        if (state == LOW) rdata_q[15:0]  <= bus.sram_rdata;
        else              rdata_q[31:16] <= bus.sram_rdata;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = LOW;
      LOW:     if (phase_end) state_nx = HIGH;
      HIGH:    if (phase_end) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready_c      = 1'b0;
    sram_addr_c  = '0;
    sram_wdata_c = '0;
    dq_oe_c      = 1'b0;
    we_n_c       = 1'b1;
    oe_n_c       = 1'b1;
    case (state)
      LOW, HIGH: begin
        sram_addr_c = {addr_q, state == HIGH};
        if (op_wr) begin
          dq_oe_c      = 1'b1;
          sram_wdata_c = (state == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
          // Strobe released on the last cycle so data/address hold past the rising we_n
          we_n_c       = !(32'(count) < 32'(WE_CYCLES));
        end else begin
          oe_n_c = 1'b0;
        end
      end
      DONE:    ready_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.ready      = ready_c;
  assign bus.freeze     = req & ~ready_c & rst;
  assign bus.rdata      = rdata_q;
  assign bus.sram_addr  = sram_addr_c;
  assign bus.sram_wdata = sram_wdata_c;
  assign bus.sram_dq_oe = dq_oe_c;
  assign bus.sram_we_n  = we_n_c;
  assign bus.sram_oe_n  = oe_n_c;
endmodule
